// File: rtl/shift_exec_pipe.sv
// Two-stage pipelined execute unit for the RV64 shift family
// (SLL/SRL/SRA and the W variants). Stage 1 captures the operands; stage 2
// holds the barrel-shifter result and drives the output port directly.
// Both stages use a valid/ready handshake and support backpressure and flush.
module shift_exec_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [1:0] KIND_SLL = 2'b00;
    localparam logic [1:0] KIND_SRA = 2'b10;
    localparam logic [1:0] KIND_RSV = 2'b11;

    // Six-layer logarithmic shifter. Layer k moves the value by 2**k when amt[k] is set.
    // An arithmetic right shift takes its fill from the operand MSB, so for W ops
    // the caller must pre-extend bit 31 into the upper word.
    function automatic logic [XLEN-1:0] barrel(input logic [XLEN-1:0] val,
                                               input logic [5:0]      amt,
                                               input logic            right,
                                               input logic            arith);
        logic signed [XLEN-1:0] s;
        s = $signed(val);
        for (int k = 0; k < 6; k++) begin
            if (amt[k]) begin
                if (!right)
                    s = s <<< (1 << k);
                else if (arith)
                    s = s >>> (1 << k);
                else
                    s = $signed($unsigned(s) >> (1 << k));
            end
        end
        return $unsigned(s);
    endfunction

    // Full op decode: operand/amount selection for W ops, the shift itself,
    // sign extension of the low word, and zeroing of the reserved encoding.
    function automatic logic [XLEN-1:0] exec(input logic [2:0]      op,
                                             input logic [XLEN-1:0] rs1,
                                             input logic [XLEN-1:0] rs2);
        logic            word;
        logic [1:0]      kind;
        logic            fill;
        logic [XLEN-1:0] operand;
        logic [5:0]      amt;
        logic [XLEN-1:0] res;
        word    = op[2];
        kind    = op[1:0];
        fill    = (kind == KIND_SRA) ? rs1[31] : 1'b0;
        operand = word ? {{32{fill}}, rs1[31:0]} : rs1;
        amt     = word ? {1'b0, rs2[4:0]} : rs2[5:0];
        res     = barrel(operand, amt, kind != KIND_SLL, kind == KIND_SRA);
        if (word)
            res = {{32{res[31]}}, res[31:0]};
        if (kind == KIND_RSV)
            res = '0;
        return res;
    endfunction

    logic             vld_p1;
    logic [2:0]       op_p1;
    logic [XLEN-1:0]  rs1_p1;
    logic [XLEN-1:0]  rs2_p1;
    logic [TAG_W-1:0] tag_p1;

    logic             vld_p2;
    logic [XLEN-1:0]  result_p2;
    logic             zero_p2;
    logic [TAG_W-1:0] tag_p2;
    logic             illegal_p2;

    logic             s2_free;
    logic             s1_adv;
    logic             accept;
    logic [XLEN-1:0]  result_c;
    logic             illegal_c;

    assign s2_free  = !vld_p2 || out_ready;
    assign s1_adv   = vld_p1 && s2_free;
    assign in_ready = !vld_p1 || s2_free;
    assign accept   = in_valid && in_ready;

    // Shift result for the op currently held in stage 1.
    always_comb begin
        result_c  = exec(op_p1, rs1_p1, rs2_p1);
        illegal_c = (op_p1[1:0] == KIND_RSV);
    end

    // ---- stage 1: operand capture ----
    // Stage-1 valid: flush kills, an accept refills, an advance without refill empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else if (flush)
            vld_p1 <= 1'b0;
        else if (accept)
            vld_p1 <= 1'b1;
        else if (s1_adv)
            vld_p1 <= 1'b0;
    end

    // Stage-1 operands load on accept and otherwise hold while stage 2 stalls.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p1  <= in_op;
            rs1_p1 <= in_rs1;
            rs2_p1 <= in_rs2;
            tag_p1 <= in_tag;
        end
    end

    // ---- stage 2: result register / output port ----
    // Stage-2 state; contents change only when stage 1 advances, so outputs hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2     <= 1'b0;
            result_p2  <= '0;
            zero_p2    <= 1'b0;
            tag_p2     <= '0;
            illegal_p2 <= 1'b0;
        end else begin
            if (flush)
                vld_p2 <= 1'b0;
            else if (s1_adv)
                vld_p2 <= 1'b1;
            else if (out_ready)
                vld_p2 <= 1'b0;
            if (s1_adv) begin
                result_p2  <= result_c;
                zero_p2    <= (result_c == '0);
                tag_p2     <= tag_p1;
                illegal_p2 <= illegal_c;
            end
        end
    end

    assign out_valid   = vld_p2;
    assign out_result  = result_p2;
    assign out_zero    = zero_p2;
    assign out_tag     = tag_p2;
    assign out_illegal = illegal_p2;

endmodule
